pll_rst_seq: RTL

Reset and lock sequencer for the HDMI clocking PLL. It drives the PLL reset and qualifies the PLL lock indication, with a timeout, bounded retries and a stability filter. Once lock is stable it releases the four per-clock-domain resets (pixel, shifted pixel, half-rate, serializer) in a fixed order. It runs on the PLL reference clock, sits beside the PLL in the HDMI top level, and every downstream reset in the HDMI path comes from it.

---
 rtl/pll_rst_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: drives the HDMI PLL reset, qualifies its lock indication
// (timeout, bounded retries, stability window) and releases the four
// per-domain resets in order once lock is stable. Single clock: refclk.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RESET_PLL | PLL held in reset for RST_HOLD_CYCLES, all domains in reset
// WAIT_LOCK | PLL running, waiting for synced lock (with timeout)
// STABLE    | lock seen, must stay high LOCK_STABLE_CYCLES in a row
// RELEASE   | domain resets released bit0..bit3, DOMAIN_GAP apart
// RUN       | all domains out of reset, lock_ok high
// FAULT     | retries exhausted, PLL held in reset until relock_req
module pll_rst_seq #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRY           = 3,
  parameter int unsigned DOMAIN_GAP          = 8
) (
  input  logic                               refclk,
  input  logic                               rst_n,
  input  logic                               pll_extlock,
  input  logic                               relock_req,
  output logic                               pll_reset,
  output logic [3:0]                         rst_out_n,
  output logic                               lock_ok,
  output logic                               fault,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
  output logic [7:0]                         lol_cnt
);

  // The counter also has to reach the last RELEASE index (3*DOMAIN_GAP).
  localparam int unsigned REL_LAST_I = 3 * DOMAIN_GAP;
  localparam int unsigned MAX_A      = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                       RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_B      = (LOCK_STABLE_CYCLES > REL_LAST_I) ?
                                       LOCK_STABLE_CYCLES : REL_LAST_I;
  localparam int unsigned MAX_CNT    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CW         = $clog2(MAX_CNT + 1);
  localparam int          RW         = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST    = CW'(REL_LAST_I);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          extlock_s1, lock_s;
  logic          enter;
  logic [RW-1:0] retry_nxt;
  logic [7:0]    lol_nxt;
  logic [CW:0]   rel_idx;
  logic [3:0]    rel_mask;

  // Two-flop synchronizer for the asynchronous PLL lock pin.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      extlock_s1 <= 1'b0;
      lock_s     <= 1'b0;
    end else begin
      extlock_s1 <= pll_extlock;
      lock_s     <= extlock_s1;
    end
  end

  // Next-state decision; relock_req beats every other transition.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    lol_nxt   = lol_cnt;
    if (relock_req) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt == TMO_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = FAULT;
            end else begin
              state_nxt = RESET_PLL;
              retry_nxt = retry_cnt + RW'(1);
            end
          end
        end
        STABLE: begin
          if (!lock_s)                 state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = RELEASE;
        end
        RELEASE, RUN: begin
          if (!lock_s) begin
            state_nxt = RESET_PLL;
            retry_nxt = '0;
            if (lol_cnt != 8'hFF) lol_nxt = lol_cnt + 8'd1;
          end else if (state == RELEASE && cnt == REL_LAST) begin
            state_nxt = RUN;
          end
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RESET_PLL;
      endcase
    end
  end

  // Release mask for the RELEASE cycle being entered: bit i once index >= i*gap.
  always_comb begin
    enter    = (state_nxt != state) || relock_req;
    rel_idx  = enter ? '0 : ({1'b0, cnt} + (CW+1)'(1));
    rel_mask = '0;
    for (int i = 0; i < 4; i++) begin
      rel_mask[i] = (rel_idx >= (CW+1)'(i * DOMAIN_GAP));
    end
  end

  // State, shared counter and registered outputs derived from the next state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_reset <= 1'b1;
      rst_out_n <= '0;
      lock_ok   <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
      lol_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (enter)            cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + CW'(1);
      retry_cnt <= retry_nxt;
      lol_cnt   <= lol_nxt;
      pll_reset <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      lock_ok   <= (state_nxt == RUN);
      fault     <= (state_nxt == FAULT);
      case (state_nxt)
        RELEASE: rst_out_n <= rel_mask;
        RUN:     rst_out_n <= 4'hF;
        default: rst_out_n <= 4'h0;
      endcase
    end
  end

endmodule
